// File: rtl/gate2_seq_pkg.sv
// Shared definitions for the two-input gate sequencer: state encoding,
// vector count and the standard truth tables used when selecting a gate.
package gate2_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int VEC_COUNT = 4;

  // truth[{A,B}]: bit0 is A=0,B=0 and bit3 is A=1,B=1
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate2_sequencer_settle_timer.sv
// Loadable down-counter that times the settle interval between driving the
// gate inputs and sampling its output. expire flags the last settle cycle.
module gate2_sequencer_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  // Load has priority; counting stops at zero so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  // Counter at 1 means this is the final settle cycle.
  assign expire = (value == CNT_W'(1));

endmodule

// File: rtl/gate2_sequencer.sv
// Drives an external 2-input gate through all four A/B combinations, waits
// SETTLE_CYCLES after each change, samples F against a latched truth table
// and reports per-vector mismatches plus an overall pass with a done pulse.
// Optional build macro GATE2_SEQ_STOP_ON_FAIL_EN: end the run at the first
// mismatching vector instead of applying all four.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// DRIVE  | A/B hold the current vector; settle timer loaded
// SETTLE | waiting for the gate output to settle
// SAMPLE | F compared with the expected bit for this vector
// DONE   | one-cycle done pulse; pass computed from fail_mask
module gate2_sequencer
  import gate2_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] truth,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t           state, state_d;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic [3:0]       truth_q;
  logic             mismatch;
  logic             stop_hit;
  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_expire;

  assign mismatch = (F != truth_q[idx]);
  assign idx_next = idx + 2'd1;

`ifdef GATE2_SEQ_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  gate2_sequencer_settle_timer #(
    .CNT_W(CNT_W)
  ) u_settle_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (tmr_en),
    .load_val(SETTLE_LD),
    .value   (tmr_value),
    .expire  (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d  = state;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: begin
        if (start) state_d = DRIVE;
      end
      DRIVE: begin
        tmr_load = 1'b1;
        state_d  = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      end
      SETTLE: begin
        tmr_en = 1'b1;
        // A zero counter here can only follow a glitch; leave rather than stall.
        if (tmr_expire || (tmr_value == '0)) state_d = SAMPLE;
      end
      SAMPLE: begin
        if ((idx == 2'(VEC_COUNT - 1)) || stop_hit) state_d = DONE;
        else                                        state_d = DRIVE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: A/B change only when entering DRIVE or DONE, so they stay
  // stable for the whole DRIVE/SETTLE/SAMPLE span of each vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      A         <= 1'b0;
      B         <= 1'b0;
      idx       <= 2'd0;
      truth_q   <= 4'd0;
      fail_mask <= 4'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            truth_q   <= truth;
            idx       <= 2'd0;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
            A         <= 1'b0;
            B         <= 1'b0;
          end
        end
        SAMPLE: begin
          fail_mask[idx] <= mismatch;
          if (state_d == DRIVE) begin
            idx <= idx_next;
            A   <= idx_next[1];
            B   <= idx_next[0];
          end else begin
            A <= 1'b0;
            B <= 1'b0;
          end
        end
        DONE: begin
          pass <= (fail_mask == 4'd0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
